panel_readback: RTL and testbench

Front-panel readback monitor. It decodes the two 8-bit seven-segment buses (showL/showR) produced by the display path back into digit codes. It publishes each settled, changed display value over a valid/ready interface, for self-test and status logging. It sits beside the display driver in the washer top and watches the same buses that go to the pins.

---
 rtl/panel_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/panel_readback.sv | 104 ++++++++++
 tb/tb_panel_readback.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared constants for the front-panel readback monitor.
// Segment patterns are active-high, bit0=a .. bit6=g, bit7=dp.
package panel_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIG_BLANK = 4'hE;
  localparam logic [3:0] DIG_BAD   = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Active-high gfedcba pattern to digit code (0-9, E=blank, F=bad).
// Ports: seg (7-bit pattern in), code (4-bit digit code out).
module seg7_decode
  import panel_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = DIG_BAD;
    unique case (1'b1)
      (seg == SEG_0):     code = 4'd0;
      (seg == SEG_1):     code = 4'd1;
      (seg == SEG_2):     code = 4'd2;
      (seg == SEG_3):     code = 4'd3;
      (seg == SEG_4):     code = 4'd4;
      (seg == SEG_5):     code = 4'd5;
      (seg == SEG_6):     code = 4'd6;
      (seg == SEG_7):     code = 4'd7;
      (seg == SEG_8):     code = 4'd8;
      (seg == SEG_9):     code = 4'd9;
      (seg == SEG_BLANK): code = DIG_BLANK;
      default:            code = DIG_BAD;
    endcase
  end

endmodule

// File: rtl/panel_readback.sv
// Readback monitor: settles, decodes and publishes the two segment buses.
// Ports: clk, rst_n, showL/showR, clr, rd_ready in; rd_* payload, ovr, err_cnt out.
module panel_readback
  import panel_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       showL,
  input  logic [7:0]       showR,
  input  logic             clr,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [3:0]       rd_left,
  output logic [3:0]       rd_right,
  output logic [1:0]       rd_dp,
  output logic             ovr,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [15:0]    raw;
  logic [15:0]    samp;
  logic [15:0]    last;
  logic [15:0]    norm;
  logic [CW-1:0]  cnt;
  logic           pubd;
  logic           settle;
  logic           fire;
  logic [3:0]     code_l;
  logic [3:0]     code_r;
  logic [1:0]     nbad;
  logic [ERR_W:0] err_sum;
  logic [ERR_W-1:0] err_nxt;

  assign raw  = {showL, showR};
  assign norm = SEG_ACTIVE_LOW ? ~samp : samp;

  seg7_decode u_dec_l (
    .seg  (norm[8+SEG_G:8+SEG_A]),
    .code (code_l)
  );

  seg7_decode u_dec_r (
    .seg  (norm[SEG_G:SEG_A]),
    .code (code_r)
  );

  // The edge on which cnt reaches CNT_MAX is the settle edge.
  assign settle = (raw == samp) && (cnt == CNT_MAX - 1'b1);
  assign fire   = settle && (!pubd || (samp != last));

  assign nbad = {1'b0, code_l == DIG_BAD}
              + {1'b0, code_r == DIG_BAD};

  assign err_sum = {1'b0, err_cnt} + (ERR_W+1)'(nbad);
  assign err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp     <= '0;
      cnt      <= '0;
      pubd     <= 1'b0;
      last     <= '0;
      rd_valid <= 1'b0;
      rd_left  <= '0;
      rd_right <= '0;
      rd_dp    <= '0;
      ovr      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (raw != samp) begin
        samp <= raw;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      if (fire) begin
        rd_left  <= code_l;
        rd_right <= code_r;
        rd_dp    <= {norm[8+SEG_DP], norm[SEG_DP]};
        last     <= samp;
        pubd     <= 1'b1;
        rd_valid <= 1'b1;
        err_cnt  <= err_nxt;
        if (rd_valid && !rd_ready) ovr <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end

      if (clr) begin
        ovr     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_panel_readback.sv
// Self-checking bench for panel_readback.
// Behavioural model plus directed literal checks.
module tb_panel_readback;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] showL = 8'hFF;
  logic [7:0] showR = 8'hFF;
  logic       clr = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [3:0] rd_left;
  logic [3:0] rd_right;
  logic [1:0] rd_dp;
  logic       ovr;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  panel_readback #(
    .STABLE_CYCLES  (S),
    .SEG_ACTIVE_LOW (1'b1),
    .ERR_W          (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .showL    (showL),
    .showR    (showR),
    .clr      (clr),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_left  (rd_left),
    .rd_right (rd_right),
    .rd_dp    (rd_dp),
    .ovr      (ovr),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] mdec(input logic [6:0] p);
    logic [6:0] pats [11];
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};
    for (int i = 0; i < 10; i++)
      if (p == pats[i]) return 4'(i);
    if (p == pats[10]) return 4'hE;
    return 4'hF;
  endfunction

  // Model: a pattern publishes once it has been seen on S+1 consecutive
  // edges (reset state counts as one sighting of all-zeros).
  logic [15:0] m_prev = '0;
  logic [15:0] m_last = '0;
  int          m_run = 1;
  bit          m_pub = 0;
  bit          mv = 0;
  logic [3:0]  ml = '0;
  logic [3:0]  mr = '0;
  logic [1:0]  md = '0;
  bit          movr = 0;
  int          merr = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] raw;
    logic [15:0] h;
    bit fire;
    int nb;
    if (!rst_n) begin
      m_prev = '0; m_last = '0; m_run = 1; m_pub = 0;
      mv = 0; ml = '0; mr = '0; md = '0; movr = 0; merr = 0;
    end else begin
      raw = {showL, showR};
      if (raw == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_prev = raw;
        m_run = 1;
      end
      fire = (m_run == S + 1) && (!m_pub || raw != m_last);
      if (fire) begin
        h = ~raw;
        if (mv && !rd_ready) movr = 1;
        ml = mdec(h[14:8]);
        mr = mdec(h[6:0]);
        md = {h[15], h[7]};
        nb = (ml == 4'hF ? 1 : 0) + (mr == 4'hF ? 1 : 0);
        merr = (merr + nb > 255) ? 255 : merr + nb;
        mv = 1;
        m_pub = 1;
        m_last = raw;
      end else if (mv && rd_ready) begin
        mv = 0;
      end
      if (clr) begin
        movr = 0;
        merr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      cmp("m_valid", int'(rd_valid), int'(mv));
      if (mv) begin
        cmp("m_left", int'(rd_left), int'(ml));
        cmp("m_right", int'(rd_right), int'(mr));
        cmp("m_dp", int'(rd_dp), int'(md));
      end
      cmp("m_ovr", int'(ovr), int'(movr));
      cmp("m_err", int'(err_cnt), merr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic [6:0] l, input logic [6:0] r);
    showL = ~{1'b0, l};
    showR = ~{1'b0, r};
  endtask

  initial begin
    rd_ready = 1'b1;
    put(7'h06, 7'h5B);
    #1;
    cmp("rst_valid", int'(rd_valid), 0);
    cmp("rst_err", int'(err_cnt), 0);
    step(2);
    rst_n = 1'b1;

    // 1: first publish lands on E4
    step(4);
    cmp("t1_before_e4", int'(rd_valid), 0);
    step(1);
    cmp("t1_valid", int'(rd_valid), 1);
    cmp("t1_left", int'(rd_left), 1);
    cmp("t1_right", int'(rd_right), 2);
    cmp("t1_dp", int'(rd_dp), 0);
    cmp("t1_err", int'(err_cnt), 0);

    // 2: short glitch back to the published value is silent
    step(1);
    put(7'h06, 7'h4F);
    step(2);
    put(7'h06, 7'h5B);
    step(8);
    cmp("t2_glitch", int'(rd_valid), 0);
    put(7'h06, 7'h4F);
    step(5);
    cmp("t2_valid", int'(rd_valid), 1);
    cmp("t2_right", int'(rd_right), 3);

    // 3: overrun while stalled, then clear
    rd_ready = 1'b0;
    put(7'h3F, 7'h3F);
    step(5);
    put(7'h07, 7'h7F);
    step(5);
    cmp("t3_valid", int'(rd_valid), 1);
    cmp("t3_left", int'(rd_left), 7);
    cmp("t3_right", int'(rd_right), 8);
    cmp("t3_ovr", int'(ovr), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    cmp("t3_clr_ovr", int'(ovr), 0);
    cmp("t3_clr_valid", int'(rd_valid), 1);

    // 4: invalid digits and error saturation
    rd_ready = 1'b1;
    put(7'h55, 7'h00);
    step(5);
    cmp("t4_left", int'(rd_left), 15);
    cmp("t4_right", int'(rd_right), 14);
    cmp("t4_err", int'(err_cnt), 1);
    for (int i = 0; i < 300; i++) begin
      put((i % 2 == 0) ? 7'h2A : 7'h55, 7'h00);
      step(5);
    end
    cmp("t4_sat", int'(err_cnt), 255);

    // 5: publish coincides with a handshake
    step(1);
    rd_ready = 1'b0;
    put(7'h06, 7'h06);
    step(5);
    cmp("t5_a_valid", int'(rd_valid), 1);
    put(7'h66, 7'h6D);
    step(4);
    rd_ready = 1'b1;
    step(1);
    cmp("t5_valid", int'(rd_valid), 1);
    cmp("t5_left", int'(rd_left), 4);
    cmp("t5_right", int'(rd_right), 5);
    cmp("t5_ovr", int'(ovr), 0);

    // 6: reset mid-settle republishes the same value
    put(7'h66, 7'h00);
    step(1);
    put(7'h66, 7'h6D);
    step(3);
    rst_n = 1'b0;
    #1;
    cmp("t6_valid", int'(rd_valid), 0);
    cmp("t6_left", int'(rd_left), 0);
    cmp("t6_right", int'(rd_right), 0);
    cmp("t6_err", int'(err_cnt), 0);
    step(2);
    rst_n = 1'b1;
    step(4);
    cmp("t6_before_e4", int'(rd_valid), 0);
    step(1);
    cmp("t6_repub", int'(rd_valid), 1);
    cmp("t6_rleft", int'(rd_left), 4);
    cmp("t6_rright", int'(rd_right), 5);

    // dp-only change republishes
    showL = ~8'hE6;
    step(5);
    cmp("dp_valid", int'(rd_valid), 1);
    cmp("dp_bits", int'(rd_dp), 2);
    cmp("dp_left", int'(rd_left), 4);

    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
